// File: rtl/harness_sequencer_if.sv
// harness_sequencer_if
// Bundles the run-control bus between the harness sequencer and its environment.
//   master modport : the sequencer. It samples start/abort/counts/errors and drives
//                    harness reset, traffic enable, tick counter and the verdict.
//   slave modport  : the environment (harness top or testbench).
// clk and rst_n are not part of the bus. They stay plain ports on the sequencer.
interface harness_sequencer_if #(
  parameter int NUM_PORTS   = 4,
  parameter int COUNT_WIDTH = 32,
  parameter int TICK_WIDTH  = 256
);
  logic                             start;
  logic                             abort;
  logic [NUM_PORTS*COUNT_WIDTH-1:0] sent_counts;
  logic [NUM_PORTS*COUNT_WIDTH-1:0] recv_counts;
  logic [NUM_PORTS-1:0]             chk_error;
  logic                             harness_rst_n;
  logic                             tg_enable;
  logic [TICK_WIDTH-1:0]            ticks;
  logic                             busy;
  logic                             done;
  logic                             pass;
  logic                             timeout;
  logic [NUM_PORTS-1:0]             err_mask;
  logic [31:0]                      drain_cycles;
  logic [2:0]                       state;

  modport master (
    input  start, abort, sent_counts, recv_counts, chk_error,
    output harness_rst_n, tg_enable, ticks, busy, done, pass, timeout,
           err_mask, drain_cycles, state
  );

  modport slave (
    output start, abort, sent_counts, recv_counts, chk_error,
    input  harness_rst_n, tg_enable, ticks, busy, done, pass, timeout,
           err_mask, drain_cycles, state
  );
endinterface

// File: rtl/harness_sequencer.sv
// harness_sequencer
// Run control for the NoC traffic test harness. One run proceeds as follows:
//   RESET  - hold the generators and checkers in reset.
//   RUN    - enable traffic for a fixed window.
//   DRAIN  - wait until the total sent equals the total received for DRAIN_QUIET
//            consecutive cycles, or until DRAIN_TIMEOUT cycles have passed.
//   REPORT - latch the verdict.
// The block also owns the global tick counter that the generators and checkers use.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset.
//   bus        : harness_sequencer_if.master. Inputs: start, abort, per-port
//                sent/recv totals and chk_error. Outputs: harness_rst_n,
//                tg_enable, ticks, busy, done, pass, timeout, err_mask,
//                drain_cycles and state. All outputs are registered.
module harness_sequencer #(
  parameter int NUM_PORTS     = 4,
  parameter int COUNT_WIDTH   = 32,
  parameter int TICK_WIDTH    = 256,
  parameter int RESET_CYCLES  = 16,
  parameter int RUN_CYCLES    = 1000,
  parameter int DRAIN_QUIET   = 8,
  parameter int DRAIN_TIMEOUT = 100000
) (
  input  logic                clk,
  input  logic                rst_n,
  harness_sequencer_if.master bus
);

  // Sums are widened by clog2(NUM_PORTS) so adding the per-port totals cannot overflow.
  localparam int SUM_W  = COUNT_WIDTH + $clog2(NUM_PORTS);
  localparam int PH_MAX = (RESET_CYCLES > RUN_CYCLES) ? RESET_CYCLES : RUN_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int Q_W    = $clog2(DRAIN_QUIET + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_REPORT = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [TICK_WIDTH-1:0] ticks_q, ticks_d;
  logic [31:0]           drain_q, drain_d;
  logic [Q_W-1:0]        quiet_q, quiet_d;
  logic [SUM_W-1:0]      sent_sum_q, recv_sum_q;
  logic [SUM_W-1:0]      sent_sum_s, recv_sum_s;
  logic                  pass_q, pass_d;
  logic                  timeout_q, timeout_d;
  logic [NUM_PORTS-1:0]  err_mask_q, err_mask_d;
  logic                  harness_rst_n_q, harness_rst_n_d;
  logic                  tg_enable_q, tg_enable_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  sum_match_s;
  logic [31:0]           drain_inc_s;
  logic [Q_W-1:0]        quiet_inc_s;

  // Add up the per-port totals. The sums are registered, which adds one cycle of latency.
  always_comb begin
    sent_sum_s = '0;
    recv_sum_s = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      sent_sum_s = sent_sum_s + SUM_W'(bus.sent_counts[i*COUNT_WIDTH +: COUNT_WIDTH]);
      recv_sum_s = recv_sum_s + SUM_W'(bus.recv_counts[i*COUNT_WIDTH +: COUNT_WIDTH]);
    end
  end

  // Next-state logic for the sequencer, its counters and the verdict.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    ticks_d     = ticks_q;
    drain_d     = drain_q;
    quiet_d     = quiet_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    err_mask_d  = err_mask_q;
    sum_match_s = (sent_sum_q == recv_sum_q);
    // drain_cycles saturates at all-ones instead of wrapping.
    drain_inc_s = (drain_q == 32'hFFFF_FFFF) ? drain_q : (drain_q + 32'd1);
    quiet_inc_s = sum_match_s ? (quiet_q + Q_W'(1)) : '0;

    if (bus.abort) begin
      // Abort returns to IDLE and clears pass. The tick counter keeps its value.
      state_d = ST_IDLE;
      phase_d = '0;
      quiet_d = '0;
      pass_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_d    = ST_RESET;
            phase_d    = '0;
            ticks_d    = '0;
            drain_d    = 32'd0;
            quiet_d    = '0;
            pass_d     = 1'b0;
            timeout_d  = 1'b0;
            err_mask_d = '0;
          end else begin
            state_d = state_q;
          end
        end
        ST_RESET: begin
          if (phase_q == PH_W'(RESET_CYCLES - 1)) begin
            state_d = ST_RUN;
            phase_d = '0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        ST_RUN: begin
          ticks_d = ticks_q + TICK_WIDTH'(1);
          if (phase_q == PH_W'(RUN_CYCLES - 1)) begin
            state_d = ST_DRAIN;
            phase_d = '0;
            quiet_d = '0;
            drain_d = 32'd0;
          end else begin
            phase_d = phase_q + PH_W'(1);
          end
        end
        ST_DRAIN: begin
          ticks_d = ticks_q + TICK_WIDTH'(1);
          drain_d = drain_inc_s;
          quiet_d = quiet_inc_s;
          // If the quiet count and the timeout are both reached on the same cycle,
          // the quiet count wins and timeout stays 0.
          if (quiet_inc_s == Q_W'(DRAIN_QUIET)) begin
            state_d = ST_REPORT;
          end else if (drain_inc_s == 32'(DRAIN_TIMEOUT)) begin
            state_d   = ST_REPORT;
            timeout_d = 1'b1;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        ST_REPORT: begin
          ticks_d    = ticks_q + TICK_WIDTH'(1);
          err_mask_d = bus.chk_error;
          pass_d     = (bus.chk_error == '0) && !timeout_q && sum_match_s;
          state_d    = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Derive the outputs from the next state so that, once registered, they line up
    // exactly with the state register.
    harness_rst_n_d = (state_d != ST_RESET);
    tg_enable_d     = (state_d == ST_RUN);
    busy_d          = (state_d == ST_RESET) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
    done_d          = (state_d == ST_DONE);
  end

  // State, counter, sum and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      phase_q         <= '0;
      ticks_q         <= '0;
      drain_q         <= 32'd0;
      quiet_q         <= '0;
      sent_sum_q      <= '0;
      recv_sum_q      <= '0;
      pass_q          <= 1'b0;
      timeout_q       <= 1'b0;
      err_mask_q      <= '0;
      harness_rst_n_q <= 1'b1;
      tg_enable_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      ticks_q         <= ticks_d;
      drain_q         <= drain_d;
      quiet_q         <= quiet_d;
      sent_sum_q      <= sent_sum_s;
      recv_sum_q      <= recv_sum_s;
      pass_q          <= pass_d;
      timeout_q       <= timeout_d;
      err_mask_q      <= err_mask_d;
      harness_rst_n_q <= harness_rst_n_d;
      tg_enable_q     <= tg_enable_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  assign bus.harness_rst_n = harness_rst_n_q;
  assign bus.tg_enable     = tg_enable_q;
  assign bus.ticks         = ticks_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.timeout       = timeout_q;
  assign bus.err_mask      = err_mask_q;
  assign bus.drain_cycles  = drain_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_harness_sequencer.sv
// tb_harness_sequencer
// Scoreboard bench for harness_sequencer.
// Traffic model: on each enabled cycle it sends one packet, visiting the ports in
// round-robin order, and the matching receive arrives 5 cycles later.
// Each run's expected verdict is pushed before the run starts. A monitor pops that
// entry when done rises and compares the verdict against it.
module tb_harness_sequencer;
  localparam int NP   = 4;
  localparam int CW   = 32;
  localparam int TW   = 8;
  localparam int RC   = 16;
  localparam int RUNC = 300;
  localparam int DQ   = 8;
  localparam int DT   = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  harness_sequencer_if #(.NUM_PORTS(NP), .COUNT_WIDTH(CW), .TICK_WIDTH(TW)) bus ();

  harness_sequencer #(
    .NUM_PORTS(NP), .COUNT_WIDTH(CW), .TICK_WIDTH(TW), .RESET_CYCLES(RC),
    .RUN_CYCLES(RUNC), .DRAIN_QUIET(DQ), .DRAIN_TIMEOUT(DT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct packed {
    logic          pass;
    logic          timeout;
    logic [NP-1:0] err_mask;
    logic [31:0]   drain;
    logic [TW-1:0] ticks;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Traffic model state.
  logic [CW-1:0] sent_c [NP];
  logic [CW-1:0] recv_c [NP];
  int            pipe_port [5];
  bit            pipe_v [5];
  int            slot;
  bit            drop_first = 1'b0;
  bit            glitch = 1'b0;
  bit            dropped;
  bit            phantom_pend;
  int            drain_neg;

  // Monitor state.
  int   rst_cnt = 0;
  int   tg_cnt = 0;
  int   busy_cnt = 0;
  logic done_prev = 1'b0;
  exp_t cur;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Hand-derived expectation. Ticks count through RUN, DRAIN and one REPORT cycle.
  function automatic exp_t mk(input logic p, input logic t, input logic [NP-1:0] e, input int dc);
    exp_t r;
    r.pass     = p;
    r.timeout  = t;
    r.err_mask = e;
    r.drain    = 32'(dc);
    r.ticks    = TW'(RUNC + dc + 1);
    return r;
  endfunction

  // Traffic generator and checker model. It is driven on negedge.
  initial begin : traffic
    for (int p = 0; p < NP; p++) begin
      sent_c[p] = '0;
      recv_c[p] = '0;
    end
    for (int s = 0; s < 5; s++) begin
      pipe_v[s]    = 1'b0;
      pipe_port[s] = 0;
    end
    slot = 0; dropped = 1'b0; phantom_pend = 1'b0; drain_neg = 0;
    bus.sent_counts = '0;
    bus.recv_counts = '0;
    forever begin
      @(negedge clk);
      if (!bus.harness_rst_n) begin
        for (int p = 0; p < NP; p++) begin
          sent_c[p] = '0;
          recv_c[p] = '0;
        end
        for (int s = 0; s < 5; s++) pipe_v[s] = 1'b0;
        slot = 0; dropped = 1'b0; phantom_pend = 1'b0; drain_neg = 0;
      end else begin
        if (pipe_v[4]) begin
          if (drop_first && !dropped) dropped = 1'b1;
          else recv_c[pipe_port[4]] = recv_c[pipe_port[4]] + 1;
        end
        for (int s = 4; s > 0; s--) begin
          pipe_v[s]    = pipe_v[s-1];
          pipe_port[s] = pipe_port[s-1];
        end
        pipe_v[0] = 1'b0;
        if (bus.tg_enable) begin
          sent_c[slot] = sent_c[slot] + 1;
          pipe_v[0]    = 1'b1;
          pipe_port[0] = slot;
          slot         = (slot + 1) % NP;
        end
        if (phantom_pend) begin
          recv_c[0]    = recv_c[0] + 1;
          phantom_pend = 1'b0;
        end
        if (bus.state == 3'd3) begin
          drain_neg++;
          if (glitch && drain_neg == 12) begin
            sent_c[0]    = sent_c[0] + 1;
            phantom_pend = 1'b1;
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        bus.sent_counts[p*CW +: CW] = sent_c[p];
        bus.recv_counts[p*CW +: CW] = recv_c[p];
      end
    end
  end

  // Scoreboard monitor: counts phase lengths and checks the verdict when done rises.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.state == 3'd0) begin
        rst_cnt = 0; tg_cnt = 0; busy_cnt = 0;
      end
      if (!bus.harness_rst_n) rst_cnt++;
      if (bus.tg_enable) tg_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.done && !done_prev) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: done rose with no run expected");
        end else begin
          cur = sb_q.pop_front();
          check("pass", 64'(bus.pass), 64'(cur.pass));
          check("timeout", 64'(bus.timeout), 64'(cur.timeout));
          check("err_mask", 64'(bus.err_mask), 64'(cur.err_mask));
          check("drain_cycles", 64'(bus.drain_cycles), 64'(cur.drain));
          check("ticks_at_done", 64'(bus.ticks), 64'(cur.ticks));
          check("reset_len", 64'(rst_cnt), 64'(RC));
          check("run_len", 64'(tg_cnt), 64'(RUNC));
          check("busy_len", 64'(busy_cnt), 64'(RC + RUNC + int'(cur.drain)));
        end
        rst_cnt = 0; tg_cnt = 0; busy_cnt = 0;
      end
      done_prev = bus.done;
    end
  end

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_sb_empty(input string name);
    int t = 0;
    while (sb_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s: run not finished after %0d cycles, %0d pending", name, t, sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int t = 0;
    while (bus.state != s && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (bus.state != s) begin
      n_bad++;
      $display("FAIL %s: state %0d, expected %0d", name, bus.state, s);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 64'(bus.state), 64'd0);
    check({tag, "_harness_rst_n"}, 64'(bus.harness_rst_n), 64'd1);
    check({tag, "_tg_enable"}, 64'(bus.tg_enable), 64'd0);
    check({tag, "_ticks"}, 64'(bus.ticks), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check({tag, "_done"}, 64'(bus.done), 64'd0);
    check({tag, "_pass"}, 64'(bus.pass), 64'd0);
    check({tag, "_timeout"}, 64'(bus.timeout), 64'd0);
    check({tag, "_err_mask"}, 64'(bus.err_mask), 64'd0);
    check({tag, "_drain_cycles"}, 64'(bus.drain_cycles), 64'd0);
  endtask

  initial begin : main
    int t;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.chk_error = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Normal run: drains 13 cycles and ticks wrap past 255.
    sb_q.push_back(mk(1'b1, 1'b0, 4'b0000, 13));
    pulse_start();
    wait_sb_empty("run_normal");

    // One packet is never received, so the drain times out.
    drop_first = 1'b1;
    sb_q.push_back(mk(1'b0, 1'b1, 4'b0000, DT));
    pulse_start();
    wait_sb_empty("run_timeout");
    drop_first = 1'b0;

    // A checker error is raised during RUN and the counts still match.
    sb_q.push_back(mk(1'b0, 1'b0, 4'b0100, 13));
    pulse_start();
    wait_state(3'd2, "err_wait_run");
    bus.chk_error = 4'b0100;
    wait_sb_empty("run_chk_error");
    bus.chk_error = '0;

    // The sums match for 7 cycles, diverge for one cycle, then need 8 fresh matches.
    glitch = 1'b1;
    sb_q.push_back(mk(1'b1, 1'b0, 4'b0000, 21));
    pulse_start();
    wait_sb_empty("run_quiet_glitch");
    glitch = 1'b0;

    // Abort in the middle of RUN.
    pulse_start();
    t = 0;
    while (!(bus.state == 3'd2 && bus.ticks == 8'd150) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("abort_reach_tick150", 64'(bus.ticks), 64'd150);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_state", 64'(bus.state), 64'd0);
    check("abort_tg_enable", 64'(bus.tg_enable), 64'd0);
    check("abort_harness_rst_n", 64'(bus.harness_rst_n), 64'd1);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_ticks", 64'(bus.ticks), 64'd150);
    repeat (3) @(negedge clk);
    check("abort_ticks_held", 64'(bus.ticks), 64'd150);

    // A fresh run after the abort restarts ticks from 0.
    sb_q.push_back(mk(1'b1, 1'b0, 4'b0000, 13));
    pulse_start();
    check("restart_state", 64'(bus.state), 64'd1);
    check("restart_ticks", 64'(bus.ticks), 64'd0);
    check("restart_harness_rst_n", 64'(bus.harness_rst_n), 64'd0);
    wait_sb_empty("run_after_abort");

    // Holding start high re-arms, so the two runs follow back to back.
    sb_q.push_back(mk(1'b1, 1'b0, 4'b0000, 13));
    sb_q.push_back(mk(1'b1, 1'b0, 4'b0000, 13));
    bus.start = 1'b1;
    t = 0;
    while (sb_q.size() == 2 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    wait_state(3'd1, "b2b_rearm");
    bus.start = 1'b0;
    wait_sb_empty("run_back_to_back");

    // Asynchronous reset during DRAIN.
    pulse_start();
    wait_state(3'd3, "arst_wait_drain");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
